// File: rtl/synapse_weight_array_pkg.sv
`default_nettype none
// ============================================================================
// Module   : synapse_weight_array_pkg
// Brief    : Shared neuron constants, synapse count helper and load FSM states.
// Revision : 1.0 - initial release
// ============================================================================
package synapse_weight_array_pkg;

  localparam int W_BITS = 2;

  localparam logic [1:0] C_IDLE   = 2'd0;
  localparam logic [1:0] C_LOAD   = 2'd1;
  localparam logic [1:0] C_COMMIT = 2'd2;

  typedef enum logic [1:0] {
    IDLE   = C_IDLE,
    LOAD   = C_LOAD,
    COMMIT = C_COMMIT
  } state_t;

  function automatic int n_syn(input int n_stage);
    return 2 ** n_stage;
  endfunction

endpackage
`default_nettype wire

// File: rtl/synapse_weight_array_synapse_gate.sv
`default_nettype none
// ============================================================================
// Module   : synapse_gate
// Brief    : Passes one synapse weight through when its spike bit is set.
// Revision : 1.0 - initial release
// ============================================================================
module synapse_gate #(
  parameter int W_BITS = 2
) (
  input  logic              i_spike,
  input  logic [W_BITS-1:0] i_weight,
  output logic [W_BITS-1:0] o_wx
);

  assign o_wx = i_spike ? i_weight : '0;

endmodule
`default_nettype wire

// File: rtl/synapse_weight_array.sv
`default_nettype none
// ============================================================================
// Module   : synapse_weight_array
// Brief    : Double-buffered synapse weights with spike-gated, registered wx bus.
// Revision : 1.0 - initial release
// ============================================================================
module synapse_weight_array #(
  parameter int N_STAGE = 5,
  parameter int W_BITS  = 2
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        load_start,
  input  logic [W_BITS-1:0]           weight_data,
  input  logic                        weight_valid,
  output logic                        weight_ready,
  output logic                        load_done,
  input  logic [2**N_STAGE-1:0]       spike_in,
  input  logic                        spike_valid,
  output logic [2**(N_STAGE+1)-1:0]   wx,
  output logic                        wx_valid
);

  import synapse_weight_array_pkg::*;

  localparam int                 C_N_SYN    = n_syn(N_STAGE);
  localparam int                 C_CNT_W    = $clog2(C_N_SYN);
  localparam logic [C_CNT_W-1:0] C_LAST_CNT = C_CNT_W'(C_N_SYN - 1);

  state_t                               r_state;
  logic [C_CNT_W-1:0]                   r_cnt;
  logic [C_N_SYN-1:0][W_BITS-1:0]       r_shadow;
  logic [C_N_SYN-1:0][W_BITS-1:0]       r_active;
  logic [C_N_SYN-1:0][W_BITS-1:0]       w_gated;
  logic                                 w_xfer;

  assign weight_ready = (r_state == LOAD);
  assign load_done    = (r_state == COMMIT);
  assign w_xfer       = weight_valid && weight_ready;

  // Weights stream into the shadow bank; only a complete load reaches the active bank.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state  <= IDLE;
      r_cnt    <= '0;
      r_shadow <= '0;
      r_active <= '0;
    end else begin
      unique case (r_state)
        IDLE: begin
          if (load_start) begin
            r_state <= LOAD;
            r_cnt   <= '0;
          end
        end
        LOAD: begin
          if (load_start) begin
            r_cnt <= '0;
          end else if (w_xfer) begin
            r_shadow[r_cnt] <= weight_data;
            r_cnt           <= r_cnt + 1'b1;
            if (r_cnt == C_LAST_CNT) begin
              r_state <= COMMIT;
            end
          end
        end
        COMMIT: begin
          r_active <= r_shadow;
          r_state  <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  for (genvar gi = 0; gi < C_N_SYN; gi++) begin : g_syn
    synapse_gate #(
      .W_BITS (W_BITS)
    ) u_gate (
      .i_spike  (spike_in[gi]),
      .i_weight (r_active[gi]),
      .o_wx     (w_gated[gi])
    );
  end

  // Spike path ignores the load FSM; a spike in the COMMIT cycle sees the old bank.
  always_ff @(posedge clk) begin
    if (reset) begin
      wx       <= '0;
      wx_valid <= 1'b0;
    end else begin
      wx_valid <= spike_valid;
      if (spike_valid) begin
        wx <= w_gated;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_synapse_weight_array.sv
`default_nettype none
// ============================================================================
// Module   : tb_synapse_weight_array
// Brief    : Directed self-checking bench for synapse_weight_array.
// Revision : 1.0 - initial release
// ============================================================================
module tb_synapse_weight_array;

  localparam logic [63:0] C_ALL3 = 64'hFFFF_FFFF_FFFF_FFFF;
  localparam logic [63:0] C_ALL2 = 64'hAAAA_AAAA_AAAA_AAAA;
  localparam logic [63:0] C_ALL1 = 64'h5555_5555_5555_5555;
  localparam logic [63:0] C_E4   = 64'hE4E4_E4E4_E4E4_E4E4;

  logic        clk;
  logic        reset;
  logic        load_start;
  logic [1:0]  weight_data;
  logic        weight_valid;
  logic        weight_ready;
  logic        load_done;
  logic [31:0] spike_in;
  logic        spike_valid;
  logic [63:0] wx;
  logic        wx_valid;

  int n_vec;
  int n_err;

  synapse_weight_array #(
    .N_STAGE (5),
    .W_BITS  (2)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .load_start   (load_start),
    .weight_data  (weight_data),
    .weight_valid (weight_valid),
    .weight_ready (weight_ready),
    .load_done    (load_done),
    .spike_in     (spike_in),
    .spike_valid  (spike_valid),
    .wx           (wx),
    .wx_valid     (wx_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
  endtask

  // Drives a full load of the 64-bit packed weight image; reports what it saw.
  task automatic run_load(input logic [63:0] w, input bit toggle,
                          output int xfers, output int done_at,
                          output int done_cnt, output int ready_cycles);
    logic [63:0] wv;
    wv = w;
    xfers = 0; done_at = -1; done_cnt = 0; ready_cycles = 0;
    spike_valid = 1'b0;
    load_start = 1'b1;
    tick();
    load_start = 1'b0;
    for (int c = 1; c <= 90; c++) begin
      if (load_done) begin
        done_cnt++;
        if (done_at < 0) done_at = c;
      end
      if (weight_ready) ready_cycles++;
      weight_valid = toggle ? ((c % 2) == 1) : 1'b1;
      weight_data  = (xfers < 32) ? wv[2*xfers +: 2] : 2'd0;
      if (weight_ready && weight_valid) xfers++;
      tick();
      if (done_at > 0 && c > done_at + 2) break;
    end
    weight_valid = 1'b0;
  endtask

  task automatic test_reset();
    spike_valid = 1'b0; spike_in = '0; load_start = 1'b0;
    weight_valid = 1'b0; weight_data = '0;
    do_reset();
    n_vec++; if (wx !== 64'h0) begin n_err++; $display("FAIL reset_wx: got %h expected %h", wx, 64'h0); end
    n_vec++; if (wx_valid !== 1'b0) begin n_err++; $display("FAIL reset_wx_valid: got %b expected 0", wx_valid); end
    n_vec++; if (load_done !== 1'b0) begin n_err++; $display("FAIL reset_load_done: got %b expected 0", load_done); end
    n_vec++; if (weight_ready !== 1'b0) begin n_err++; $display("FAIL reset_weight_ready: got %b expected 0", weight_ready); end
    spike_valid = 1'b1; spike_in = 32'hFFFF_FFFF;
    tick();
    spike_valid = 1'b0;
    n_vec++; if (wx !== 64'h0) begin n_err++; $display("FAIL idle_spike_wx: got %h expected %h", wx, 64'h0); end
    n_vec++; if (wx_valid !== 1'b1) begin n_err++; $display("FAIL idle_spike_valid: got %b expected 1", wx_valid); end
    n_vec++; if (weight_ready !== 1'b0) begin n_err++; $display("FAIL idle_ready: got %b expected 0", weight_ready); end
    tick();
    n_vec++; if (wx_valid !== 1'b0) begin n_err++; $display("FAIL idle_valid_drop: got %b expected 0", wx_valid); end
  endtask

  task automatic test_load_full();
    int xf, da, dc, rc;
    run_load(C_E4, 1'b0, xf, da, dc, rc);
    n_vec++; if (xf !== 32) begin n_err++; $display("FAIL full_xfers: got %0d expected 32", xf); end
    n_vec++; if (da !== 33) begin n_err++; $display("FAIL full_done_cycle: got %0d expected 33", da); end
    n_vec++; if (dc !== 1) begin n_err++; $display("FAIL full_done_pulses: got %0d expected 1", dc); end
    n_vec++; if (rc !== 32) begin n_err++; $display("FAIL full_ready_cycles: got %0d expected 32", rc); end
    spike_valid = 1'b1; spike_in = 32'hFFFF_FFFF;
    tick();
    spike_valid = 1'b0;
    n_vec++; if (wx !== C_E4) begin n_err++; $display("FAIL full_wx: got %h expected %h", wx, C_E4); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] sp [4];
    logic [63:0] ex [4];
    sp[0] = 32'hFFFF_0000; ex[0] = 64'hE4E4_E4E4_0000_0000;
    sp[1] = 32'h0000_FFFF; ex[1] = 64'h0000_0000_E4E4_E4E4;
    sp[2] = 32'hAAAA_AAAA; ex[2] = 64'hC4C4_C4C4_C4C4_C4C4;
    sp[3] = 32'h5555_5555; ex[3] = 64'h2020_2020_2020_2020;
    spike_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      spike_in = sp[i];
      tick();
      n_vec++; if (wx !== ex[i] || wx_valid !== 1'b1) begin n_err++; $display("FAIL b2b_%0d: got %h/%b expected %h/1", i, wx, wx_valid, ex[i]); end
    end
    spike_valid = 1'b0; spike_in = 32'hFFFF_FFFF;
    tick();
    n_vec++; if (wx !== ex[3] || wx_valid !== 1'b0) begin n_err++; $display("FAIL b2b_hold: got %h/%b expected %h/0", wx, wx_valid, ex[3]); end
  endtask

  task automatic test_load_toggle();
    int xf, da, dc, rc;
    do_reset();
    run_load(C_E4, 1'b1, xf, da, dc, rc);
    n_vec++; if (xf !== 32) begin n_err++; $display("FAIL tog_xfers: got %0d expected 32", xf); end
    n_vec++; if (da !== 64) begin n_err++; $display("FAIL tog_done_cycle: got %0d expected 64", da); end
    n_vec++; if (rc !== 63) begin n_err++; $display("FAIL tog_ready_cycles: got %0d expected 63", rc); end
    n_vec++; if (weight_ready !== 1'b0) begin n_err++; $display("FAIL tog_ready_after: got %b expected 0", weight_ready); end
    spike_valid = 1'b1; spike_in = 32'hFFFF_FFFF;
    tick();
    spike_valid = 1'b0;
    n_vec++; if (wx !== C_E4) begin n_err++; $display("FAIL tog_wx: got %h expected %h", wx, C_E4); end
  endtask

  task automatic test_restart();
    int xf, da, dc, rc;
    int done_at, done_cnt;
    logic [63:0] exp_wx;
    run_load(C_ALL3, 1'b0, xf, da, dc, rc);
    load_start = 1'b1;
    tick();
    load_start = 1'b0;
    weight_valid = 1'b1; weight_data = 2'd1;
    spike_valid = 1'b1; spike_in = 32'hFFFF_FFFF;
    for (int i = 0; i < 10; i++) begin
      tick();
      n_vec++; if (wx !== C_ALL3) begin n_err++; $display("FAIL rst_partial_wx_%0d: got %h expected %h", i, wx, C_ALL3); end
    end
    load_start = 1'b1;
    tick();
    load_start = 1'b0; weight_data = 2'd2;
    done_at = -1; done_cnt = 0;
    for (int j = 0; j <= 40; j++) begin
      if (load_done) begin
        done_cnt++;
        if (done_at < 0) done_at = j;
      end
      if (j >= 1) begin
        exp_wx = (j <= 33) ? C_ALL3 : C_ALL2;
        n_vec++; if (wx !== exp_wx) begin n_err++; $display("FAIL restart_wx_%0d: got %h expected %h", j, wx, exp_wx); end
      end
      tick();
    end
    weight_valid = 1'b0; spike_valid = 1'b0;
    n_vec++; if (done_at !== 32) begin n_err++; $display("FAIL restart_done_cycle: got %0d expected 32", done_at); end
    n_vec++; if (done_cnt !== 1) begin n_err++; $display("FAIL restart_done_pulses: got %0d expected 1", done_cnt); end
  endtask

  task automatic test_commit_spike();
    int xf, da, dc, rc;
    bit seen;
    run_load(C_ALL3, 1'b0, xf, da, dc, rc);
    load_start = 1'b1;
    tick();
    load_start = 1'b0;
    weight_valid = 1'b1; weight_data = 2'd1;
    spike_valid = 1'b0; spike_in = 32'h0000_0001;
    seen = 1'b0;
    for (int c = 0; c < 60 && !seen; c++) begin
      if (load_done) seen = 1'b1;
      else tick();
    end
    n_vec++; if (seen !== 1'b1) begin n_err++; $display("FAIL commit_timeout: got %b expected 1", seen); end
    spike_valid = 1'b1;
    tick();
    n_vec++; if (wx !== 64'h3) begin n_err++; $display("FAIL commit_old_wx: got %h expected %h", wx, 64'h3); end
    tick();
    n_vec++; if (wx !== 64'h1) begin n_err++; $display("FAIL commit_new_wx: got %h expected %h", wx, 64'h1); end
    spike_valid = 1'b0; weight_valid = 1'b0;
    spike_in = 32'hFFFF_FFFF; spike_valid = 1'b1;
    tick();
    spike_valid = 1'b0;
    n_vec++; if (wx !== C_ALL1) begin n_err++; $display("FAIL commit_all_wx: got %h expected %h", wx, C_ALL1); end
  endtask

  task automatic test_reset_midload();
    int done_cnt, ready_cnt;
    load_start = 1'b1;
    tick();
    load_start = 1'b0;
    weight_valid = 1'b1; weight_data = 2'd2;
    repeat (20) tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    n_vec++; if (weight_ready !== 1'b0) begin n_err++; $display("FAIL midrst_ready: got %b expected 0", weight_ready); end
    n_vec++; if (wx !== 64'h0) begin n_err++; $display("FAIL midrst_wx: got %h expected %h", wx, 64'h0); end
    n_vec++; if (load_done !== 1'b0) begin n_err++; $display("FAIL midrst_done: got %b expected 0", load_done); end
    done_cnt = 0; ready_cnt = 0;
    for (int c = 0; c < 40; c++) begin
      if (load_done) done_cnt++;
      if (weight_ready) ready_cnt++;
      tick();
    end
    weight_valid = 1'b0;
    n_vec++; if (done_cnt !== 0) begin n_err++; $display("FAIL midrst_done_pulses: got %0d expected 0", done_cnt); end
    n_vec++; if (ready_cnt !== 0) begin n_err++; $display("FAIL midrst_ready_cycles: got %0d expected 0", ready_cnt); end
    spike_valid = 1'b1; spike_in = 32'hFFFF_FFFF;
    tick();
    spike_valid = 1'b0;
    n_vec++; if (wx !== 64'h0 || wx_valid !== 1'b1) begin n_err++; $display("FAIL midrst_spike: got %h/%b expected %h/1", wx, wx_valid, 64'h0); end
  endtask

  initial begin
    n_vec = 0; n_err = 0;
    reset = 1'b1; load_start = 1'b0; weight_data = '0; weight_valid = 1'b0;
    spike_in = '0; spike_valid = 1'b0;
    test_reset();
    test_load_full();
    test_back_to_back();
    test_load_toggle();
    test_restart();
    test_commit_spike();
    test_reset_midload();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/synapse_weight_array.md
Name: synapse_weight_array

Overview:
- Synapse front end that produces the packed weighted-input bus `wx` consumed by the neuron's `adder_tree`.
- Holds one 2-bit unsigned weight per synapse, loaded serially through a valid/ready stream into a shadow bank, then committed atomically to the active bank.
- On each accepted spike vector, registers `wx[2i+1:2i] = spike_in[i] ? w_active[i] : 0` for the downstream tree.

Parameters:
- N_STAGE, 5, adder-tree depth; number of synapses N_SYN = 2**N_STAGE; `wx` width = 2**(N_STAGE+1).
- W_BITS, 2, weight width; fixed at 2 to match the tree's first-stage operand width.

Ports:
- clk  input  1  system clock.
- reset  input  1  synchronous, active-high reset.
- load_start  input  1  one-cycle pulse; begins or restarts a weight load.
- weight_data  input  2  next weight, synapse 0 first.
- weight_valid  input  1  `weight_data` is valid.
- weight_ready  output  1  block accepts `weight_data` this cycle.
- load_done  output  1  one-cycle pulse; shadow bank committed to active bank.
- spike_in  input  N_SYN  presynaptic spike vector; bit i belongs to synapse i.
- spike_valid  input  1  `spike_in` is valid this cycle.
- wx  output  2*N_SYN  registered weighted inputs; synapse i occupies `wx[2i+1:2i]`.
- wx_valid  output  1  `wx` was updated this cycle.

Behaviour:
- Clock and reset: one clock `clk`. Reset is synchronous and active-high on `reset`.
- Reset values:
  - state = IDLE, load counter = 0, active and shadow banks = 0.
  - `wx` = 0, `wx_valid` = 0, `load_done` = 0, `weight_ready` = 0.
- FSM states are IDLE, LOAD and COMMIT.
  - IDLE: `weight_ready` = 0. `load_start` moves to LOAD with counter = 0.
  - LOAD: `weight_ready` = 1. A transfer occurs when `weight_valid && weight_ready`.
    - On transfer: shadow[counter] <= `weight_data`, counter++.
    - On the transfer with counter == N_SYN-1, go to COMMIT.
    - `load_start` in LOAD restarts: counter <= 0, and any same-cycle transfer is discarded. Shadow contents are stale but get overwritten; the active bank is untouched.
  - COMMIT: lasts exactly one cycle.
    - active <= shadow, `load_done` = 1, `weight_ready` = 0, then go to IDLE.
    - `load_start` in COMMIT is ignored.
- Load counter width is clog2(N_SYN). It never wraps, because the FSM leaves LOAD at N_SYN-1.
- Spike path is independent of the FSM and operates in every state.
  - If `spike_valid`: `wx` <= gated active weights, `wx_valid` <= 1. Otherwise `wx` holds and `wx_valid` <= 0.
  - Latency is 1 cycle from `spike_valid` to `wx_valid`. There is no backpressure, so one vector is accepted per cycle.
- Simultaneous events:
  - A spike in the COMMIT cycle uses the old active weights.
  - The first spike after the `load_done` cycle uses the new weights.
  - A load in progress never alters `wx`. Partial loads never reach the active bank.
- Reset mid-load returns to IDLE, clears both banks and drops `weight_ready` the next cycle.
- Arithmetic: purely bitwise gating, no carries. Maximum tree sum is 3*N_SYN, which fits the tree's N_STAGE+2-bit output.

Decomposition:
- Shared neuron package holds:
  - W_BITS = 2;
  - N_SYN(N_STAGE) = 2**N_STAGE;
  - FSM state typedef {IDLE, LOAD, COMMIT}, 2-bit encoding.
- One natural sub-module, `synapse_gate`: a combinational per-synapse AND of spike with weight, instantiated N_SYN times via generate.
- FSM, counter and both banks stay in the top module.

Test Plan:
- Reset, then `spike_valid`=1 with `spike_in`=all-ones → next cycle `wx`=0 and `wx_valid`=1; `weight_ready`=0 while IDLE.
- Load weights i%4 for i=0..31 with `weight_valid` held high → exactly 32 transfers, `load_done` pulse in cycle 33 after `load_start`; then `spike_in`=0xFFFFFFFF → `wx`=0xE4E4...E4 (64 bits).
- Same load with `weight_valid` toggling every other cycle → still 32 transfers and identical active bank; `weight_ready` high only in LOAD.
- Active = all 3s. Start a load of all 1s, and after 10 weights pulse `load_start` again, then complete 32 weights of 2 → active = all 2s, `load_done` pulses once, spikes during the load still show 3s.
- Spike 0x00000001 in the COMMIT cycle (old weights 3, new 1) → `wx`[1:0]=3. Same spike next cycle → `wx`[1:0]=1.
- Assert `reset` after 20 weights of a load → next cycle state IDLE, `weight_ready`=0, `wx`=0, `load_done` never pulses, and a subsequent all-ones spike gives `wx`=0.
